// File: rtl/pixel_fetch.sv
// pixel_fetch: framebuffer pixel fetch for a VGA-style raster.
//
// Tracks the raster position from the incoming active-low syncs, issues one
// framebuffer read per active pixel, and turns the returned RGB332 byte into
// DAC colour two cycles after the read.
//
// Ports:
//   CLK       in   single clock, all logic on posedge
//   NRST      in   synchronous active-low reset
//   H_SYNC    in   active-low horizontal sync from the sync generator
//   V_SYNC    in   active-low vertical sync from the sync generator
//   MEM_RD    out  framebuffer read strobe
//   MEM_ADDR  out  framebuffer pixel address (19 bit), valid with MEM_RD
//   MEM_DATA  in   RGB332 pixel, valid the cycle after MEM_RD
//   HS_OUT    out  H_SYNC delayed to match the pixel pipeline
//   VS_OUT    out  V_SYNC delayed to match the pixel pipeline
//   DE        out  display enable
//   VGA_R/G/B out  pixel colour (3/3/2 bit), zero outside DE
module pixel_fetch #(
  parameter int H_START  = 144,
  parameter int V_START  = 35,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic        CLK,
  input  logic        NRST,
  input  logic        H_SYNC,
  input  logic        V_SYNC,
  output logic        MEM_RD,
  output logic [18:0] MEM_ADDR,
  input  logic [7:0]  MEM_DATA,
  output logic        HS_OUT,
  output logic        VS_OUT,
  output logic        DE,
  output logic [2:0]  VGA_R,
  output logic [2:0]  VGA_G,
  output logic [1:0]  VGA_B
);

  // Window bounds widened to 11 bits so the exclusive upper limit can reach 1024.
  localparam logic [10:0] H_LO = 11'(H_START);
  localparam logic [10:0] H_HI = 11'(H_START + H_ACTIVE);
  localparam logic [10:0] V_LO = 11'(V_START);
  localparam logic [10:0] V_HI = 11'(V_START + V_ACTIVE);

  // Position counters stop at all-ones so a missing sync cannot wrap back
  // into the active window.
  function automatic logic [9:0] sat_inc(input logic [9:0] val);
    return (val == 10'h3FF) ? val : (val + 10'd1);
  endfunction

  logic        hs_r;
  logic        vs_r;
  logic        hs_d2_r;
  logic        hs_d3_r;
  logic        vs_d2_r;
  logic        vs_d3_r;
  logic [9:0]  h_pos_r;
  logic [9:0]  v_pos_r;
  logic        locked_r;
  logic [18:0] addr_cnt_r;
  logic        rd_d1_r;

  logic        h_fall_s;
  logic        v_fall_s;
  logic        h_in_s;
  logic        v_in_s;
  logic        active_s;

  // Sync edge detection and active-window decode.
  always_comb begin
    h_fall_s = ~H_SYNC & hs_r;
    v_fall_s = ~V_SYNC & vs_r;
    h_in_s   = ({1'b0, h_pos_r} >= H_LO) && ({1'b0, h_pos_r} < H_HI);
    v_in_s   = ({1'b0, v_pos_r} >= V_LO) && ({1'b0, v_pos_r} < V_HI);
    active_s = locked_r & h_in_s & v_in_s;
  end

  // Sync capture; the first stage doubles as the edge-detect register and
  // the chain is four deep to line the syncs up with the pixel pipeline.
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      hs_r    <= 1'b0;
      hs_d2_r <= 1'b0;
      hs_d3_r <= 1'b0;
      HS_OUT  <= 1'b0;
      vs_r    <= 1'b0;
      vs_d2_r <= 1'b0;
      vs_d3_r <= 1'b0;
      VS_OUT  <= 1'b0;
    end else begin
      hs_r    <= H_SYNC;
      hs_d2_r <= hs_r;
      hs_d3_r <= hs_d2_r;
      HS_OUT  <= hs_d3_r;
      vs_r    <= V_SYNC;
      vs_d2_r <= vs_r;
      vs_d3_r <= vs_d2_r;
      VS_OUT  <= vs_d3_r;
    end
  end

  // Raster position and frame lock; a V fall overrides a coincident H fall
  // so the first line of a frame is line 0.
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      h_pos_r  <= 10'd0;
      v_pos_r  <= 10'd0;
      locked_r <= 1'b0;
    end else begin
      if (h_fall_s) begin
        h_pos_r <= 10'd0;
      end else begin
        h_pos_r <= sat_inc(h_pos_r);
      end
      if (v_fall_s) begin
        v_pos_r <= 10'd0;
      end else if (h_fall_s) begin
        v_pos_r <= sat_inc(v_pos_r);
      end else begin
        v_pos_r <= v_pos_r;
      end
      if (v_fall_s) begin
        locked_r <= 1'b1;
      end else begin
        locked_r <= locked_r;
      end
    end
  end

  // Read strobe and address; the counter is cleared on every V fall so a
  // truncated frame cannot shift the next frame's addressing.
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      MEM_RD     <= 1'b0;
      MEM_ADDR   <= 19'd0;
      addr_cnt_r <= 19'd0;
    end else begin
      MEM_RD <= active_s;
      if (active_s) begin
        MEM_ADDR <= addr_cnt_r;
      end else begin
        MEM_ADDR <= MEM_ADDR;
      end
      if (v_fall_s) begin
        addr_cnt_r <= 19'd0;
      end else if (active_s) begin
        addr_cnt_r <= addr_cnt_r + 19'd1;
      end else begin
        addr_cnt_r <= addr_cnt_r;
      end
    end
  end

  // Pixel capture: the byte arrives one cycle after the read, so DE and the
  // colour registers are loaded from the once-delayed read strobe.
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      rd_d1_r <= 1'b0;
      DE      <= 1'b0;
      VGA_R   <= 3'd0;
      VGA_G   <= 3'd0;
      VGA_B   <= 2'd0;
    end else begin
      rd_d1_r <= MEM_RD;
      DE      <= rd_d1_r;
      if (rd_d1_r) begin
        VGA_R <= MEM_DATA[7:5];
        VGA_G <= MEM_DATA[4:2];
        VGA_B <= MEM_DATA[1:0];
      end else begin
        VGA_R <= 3'd0;
        VGA_G <= 3'd0;
        VGA_B <= 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_pixel_fetch.sv
// tb_pixel_fetch: directed bench for pixel_fetch with a cycle model.
// Horizontal timing is nominal (800 clocks, 96-clock sync); the frame is
// shortened to 10 lines with V_START=3 and V_ACTIVE=4 to keep runs short.
module tb_pixel_fetch;

  localparam int H_TOTAL   = 800;
  localparam int HS_LEN    = 96;
  localparam int V_TOTAL   = 10;
  localparam int VS_LINES  = 2;
  localparam int P_HSTART  = 144;
  localparam int P_VSTART  = 3;
  localparam int P_HACTIVE = 640;
  localparam int P_VACTIVE = 4;
  localparam int FRAME_PIX = P_HACTIVE * P_VACTIVE;

  logic        CLK;
  logic        NRST;
  logic        H_SYNC;
  logic        V_SYNC;
  logic        MEM_RD;
  logic [18:0] MEM_ADDR;
  logic [7:0]  MEM_DATA;
  logic        HS_OUT;
  logic        VS_OUT;
  logic        DE;
  logic [2:0]  VGA_R;
  logic [2:0]  VGA_G;
  logic [1:0]  VGA_B;

  pixel_fetch #(
    .H_START (P_HSTART),
    .V_START (P_VSTART),
    .H_ACTIVE(P_HACTIVE),
    .V_ACTIVE(P_VACTIVE)
  ) dut (
    .CLK     (CLK),
    .NRST    (NRST),
    .H_SYNC  (H_SYNC),
    .V_SYNC  (V_SYNC),
    .MEM_RD  (MEM_RD),
    .MEM_ADDR(MEM_ADDR),
    .MEM_DATA(MEM_DATA),
    .HS_OUT  (HS_OUT),
    .VS_OUT  (VS_OUT),
    .DE      (DE),
    .VGA_R   (VGA_R),
    .VGA_G   (VGA_G),
    .VGA_B   (VGA_B)
  );

  int total = 0;
  int bad   = 0;
  bit e3    = 1'b0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Framebuffer: answers one cycle after the read, either a constant or the
  // low address byte.
  initial MEM_DATA = 8'h00;
  always @(posedge CLK) MEM_DATA <= e3 ? 8'hE3 : MEM_ADDR[7:0];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 25) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_en = 1'b0;
  int m_h, m_v, m_acnt, m_addr, m_addr_d;
  bit m_lock, m_rd, m_rd_d, m_de, m_ph, m_pv;
  int m_pix;
  bit hh[4];
  bit vh[4];
  bit mf_h, mf_v, m_act;

  always @(posedge CLK) begin
    if (!NRST) begin
      m_en = 1'b1;
      m_h = 0; m_v = 0; m_acnt = 0; m_addr = 0; m_addr_d = 0;
      m_lock = 0; m_rd = 0; m_rd_d = 0; m_de = 0; m_pix = 0; m_ph = 0; m_pv = 0;
      for (int k = 0; k < 4; k++) begin hh[k] = 0; vh[k] = 0; end
    end else begin
      mf_h  = m_ph && !H_SYNC;
      mf_v  = m_pv && !V_SYNC;
      m_act = m_lock && (m_h >= P_HSTART) && (m_h < P_HSTART + P_HACTIVE)
              && (m_v >= P_VSTART) && (m_v < P_VSTART + P_VACTIVE);
      m_de  = m_rd_d;
      m_pix = m_rd_d ? (e3 ? 227 : (m_addr_d % 256)) : 0;
      m_rd_d = m_rd;
      m_addr_d = m_addr;
      m_rd = m_act;
      if (m_act) m_addr = m_acnt;
      if (mf_v) m_acnt = 0; else if (m_act) m_acnt++;
      m_h = mf_h ? 0 : ((m_h < 1023) ? m_h + 1 : 1023);
      if (mf_v) m_v = 0; else if (mf_h) m_v = (m_v < 1023) ? m_v + 1 : 1023;
      if (mf_v) m_lock = 1;
      for (int k = 3; k > 0; k--) begin hh[k] = hh[k-1]; vh[k] = vh[k-1]; end
      hh[0] = H_SYNC;
      vh[0] = V_SYNC;
      m_ph = H_SYNC;
      m_pv = V_SYNC;
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge CLK) begin
    if (m_en) begin
      chk("MEM_RD",   MEM_RD,        m_rd);
      chk("MEM_ADDR", MEM_ADDR,      m_addr);
      chk("DE",       DE,            m_de);
      chk("VGA_R",    VGA_R,         (m_pix / 32) % 8);
      chk("VGA_G",    VGA_G,         (m_pix / 4) % 8);
      chk("VGA_B",    VGA_B,         m_pix % 4);
      chk("HS_OUT",   HS_OUT,        hh[3]);
      chk("VS_OUT",   VS_OUT,        vh[3]);
      chk("h_pos",    dut.h_pos_r,   m_h);
      chk("v_pos",    dut.v_pos_r,   m_v);
    end
  end

  // Running totals used by the directed checks.
  int de_total = 0;
  int last_addr = -1;
  always @(negedge CLK) begin
    if (DE === 1'b1) de_total++;
    if (MEM_RD === 1'b1) last_addr = MEM_ADDR;
  end

  // ---------------- directed stimulus ----------------
  int  line_de[V_TOTAL];
  bit  first_seen;
  int  first_i;
  int  first_addr;
  bit  chk_vfall = 1'b0;
  bit  chk_blank = 1'b0;
  int  de_after_rst;
  int  e3_bad = 0;
  int  e3_de  = 0;

  task automatic run_line(input int ln, input bit vlow, input int early_at,
                          input int rst_at, input bit nohs);
    int de0;
    de0 = de_total;
    for (int i = 0; i < H_TOTAL; i++) begin
      @(negedge CLK);
      if (ln == P_VSTART && !first_seen && MEM_RD === 1'b1) begin
        first_seen = 1'b1;
        first_i    = i;
        first_addr = MEM_ADDR;
      end
      if (chk_vfall && ln == 0 && i == 1) begin
        chk("same_edge_v_pos", dut.v_pos_r, 0);
        chk("same_edge_addr_cnt", dut.addr_cnt_r, 0);
      end
      if (chk_blank && ln == P_VSTART && i == 0)
        chk("blank_until_next_frame", de_total - de_after_rst, 0);
      if (early_at >= 0) begin
        if (i == early_at + 1) chk("early_h_pos_restart", dut.h_pos_r, 0);
        if (i == early_at + 3) chk("early_hs_out_still_high", HS_OUT, 1);
        if (i == early_at + 4) chk("early_hs_out_low", HS_OUT, 0);
      end
      if (rst_at >= 0 && i == rst_at + 1) begin
        chk("rst_MEM_RD", MEM_RD, 0);
        chk("rst_MEM_ADDR", MEM_ADDR, 0);
        chk("rst_DE", DE, 0);
        chk("rst_RGB", {VGA_R, VGA_G, VGA_B}, 0);
        chk("rst_syncs", {HS_OUT, VS_OUT}, 0);
        de_after_rst = de_total;
      end
      if (e3) begin
        if (DE === 1'b1) begin
          e3_de++;
          if (VGA_R !== 3'd7 || VGA_G !== 3'd0 || VGA_B !== 2'd3) e3_bad++;
        end else if ({VGA_R, VGA_G, VGA_B} !== 8'd0) begin
          e3_bad++;
        end
      end
      NRST   = (i == rst_at) ? 1'b0 : 1'b1;
      H_SYNC = ((!nohs && i < HS_LEN) || (early_at >= 0 && i >= early_at && i < early_at + HS_LEN)) ? 1'b0 : 1'b1;
      V_SYNC = vlow ? 1'b0 : 1'b1;
    end
    line_de[ln] = de_total - de0;
  endtask

  task automatic run_frame(input int early_line, input int rst_line, input int nohs_line);
    first_seen = 1'b0;
    first_i    = -1;
    first_addr = -1;
    for (int l = 0; l < V_TOTAL; l++)
      run_line(l, l < VS_LINES, (l == early_line) ? 400 : -1,
               (l == rst_line) ? 300 : -1, l == nohs_line);
  endtask

  int de_f;

  initial begin
    NRST   = 1'b0;
    H_SYNC = 1'b1;
    V_SYNC = 1'b1;
    repeat (3) @(negedge CLK);
    chk("reset_MEM_RD", MEM_RD, 0);
    chk("reset_MEM_ADDR", MEM_ADDR, 0);
    chk("reset_DE", DE, 0);
    chk("reset_RGB", {VGA_R, VGA_G, VGA_B}, 0);
    chk("reset_syncs", {HS_OUT, VS_OUT}, 0);
    chk("reset_lock_cnt", {dut.locked_r, dut.addr_cnt_r}, 0);
    NRST = 1'b1;

    // Unlocked lines: no reads may appear before the first V fall.
    run_line(5, 1'b0, -1, -1, 1'b0);
    run_line(5, 1'b0, -1, -1, 1'b0);
    chk("unlocked_no_de", de_total, 0);

    // Frame 1: nominal.
    de_f = de_total;
    run_frame(-1, -1, -1);
    chk("f1_first_rd_latency", first_i - 1, 145);
    chk("f1_first_addr", first_addr, 0);
    chk("f1_line_de", line_de[P_VSTART + 1], 640);
    chk("f1_frame_de", de_total - de_f, FRAME_PIX);
    chk("f1_last_addr", last_addr, FRAME_PIX - 1);
    chk("f1_addr_cnt_end", dut.addr_cnt_r, FRAME_PIX);

    // Frame 2: coincident H/V falls at frame start, addressing restarts.
    chk_vfall = 1'b1;
    de_f = de_total;
    run_frame(-1, -1, -1);
    chk_vfall = 1'b0;
    chk("f2_first_addr", first_addr, 0);
    chk("f2_first_rd_latency", first_i - 1, 145);
    chk("f2_frame_de", de_total - de_f, FRAME_PIX);
    chk("f2_last_addr", last_addr, FRAME_PIX - 1);

    // Frame 3: constant colour, early H_SYNC in the first active line.
    e3 = 1'b1;
    run_frame(P_VSTART, -1, -1);
    e3 = 1'b0;
    chk("e3_colour_errors", e3_bad, 0);
    chk("e3_saw_de", e3_de > 0, 1);

    // Frame 4: reset mid-line; frame 5 must stay blank until its active lines.
    run_frame(-1, P_VSTART + 1, -1);
    chk_blank = 1'b1;
    de_f = de_total;
    run_frame(-1, -1, -1);
    chk_blank = 1'b0;
    chk("f5_frame_de", de_total - de_f, FRAME_PIX);
    chk("f5_first_addr", first_addr, 0);

    // Frame 6: one H_SYNC missing; the position saturates and that line is dark.
    run_frame(-1, -1, P_VSTART + 1);
    chk("nohs_line_de", line_de[P_VSTART + 1], 0);
    chk("nohs_line_de_next", line_de[P_VSTART + 2], 640);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
